line_mem: RTL and testbench



---
 rtl/line_mem_pkg.sv | 19 +
 rtl/line_mem_array.sv | 35 +++
 rtl/line_mem.sv | 129 ++++++++++++
 tb/tb_line_mem.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_mem_pkg.sv
// Shared types and constants for the line_mem backing memory.
//   line_t      : one 128-bit cache line
//   lm_state_t  : request-serving FSM states
//   LatCntWidth : width of the latency down-counter (covers latencies up to 255)
package line_mem_def;

  typedef logic [127:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    R_WAIT,
    R_RESP,
    W_WAIT,
    W_RESP
  } lm_state_t;

  localparam int unsigned LatCntWidth = 8;

endpackage

// File: rtl/line_mem_array.sv
// Line storage for line_mem: 2^LINE_IDX_BITS lines of 128 bits.
// Ports:
//   clk   : clock, write on posedge
//   we    : write enable
//   waddr : line index to write
//   wdata : line to write
//   raddr : line index to read (asynchronous read)
//   rdata : line stored at raddr
// Contents start at zero and are never cleared by reset.
module line_mem_array
  import line_mem_def::*;
#(
  parameter int unsigned LINE_IDX_BITS = 12
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [LINE_IDX_BITS-1:0] waddr,
  input  line_t                    wdata,
  input  logic [LINE_IDX_BITS-1:0] raddr,
  output line_t                    rdata
);

  localparam int unsigned Depth = 1 << LINE_IDX_BITS;

  line_t mem [Depth] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/line_mem.sv
// Backing main memory for the L1 data cache: serves 128-bit line fills and
// writebacks one at a time, each after a fixed configurable latency.
// Ports:
//   clk, RESET                 : clock, synchronous active-high reset
//   read_addr/_valid/_ready    : read request (line = addr[LINE_IDX_BITS+3:4])
//   read_data/_valid/_ready    : read response, held stable until taken
//   write_addr/_valid/_ready   : write request, write_data sampled with it
//   write_data                 : full line to store
//   write_resp_valid/_ready    : write committed response
module line_mem
  import line_mem_def::*;
#(
  parameter int unsigned LINE_IDX_BITS = 12,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 4
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [31:0] read_addr,
  input  logic        read_addr_valid,
  output logic        read_addr_ready,
  output line_t       read_data,
  output logic        read_data_valid,
  input  logic        read_data_ready,
  input  logic [31:0] write_addr,
  input  logic        write_addr_valid,
  output logic        write_addr_ready,
  input  line_t       write_data,
  output logic        write_resp_valid,
  input  logic        write_resp_ready
);

  initial begin
    assert (READ_LATENCY >= 1 && READ_LATENCY <= 255)
      else $fatal(1, "line_mem: READ_LATENCY out of range 1..255");
    assert (WRITE_LATENCY >= 1 && WRITE_LATENCY <= 255)
      else $fatal(1, "line_mem: WRITE_LATENCY out of range 1..255");
  end

  localparam logic [LatCntWidth-1:0] RdCntInit = LatCntWidth'(READ_LATENCY - 1);
  localparam logic [LatCntWidth-1:0] WrCntInit = LatCntWidth'(WRITE_LATENCY - 1);

  lm_state_t                state_q;
  logic [LatCntWidth-1:0]   cnt_q;
  logic [LINE_IDX_BITS-1:0] idx_q;
  line_t                    wdata_q;
  line_t                    arr_rdata;
  logic                     arr_we;

  // Only the line index is decoded; byte offset and upper bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{read_addr[31:LINE_IDX_BITS+4], read_addr[3:0],
                              write_addr[31:LINE_IDX_BITS+4], write_addr[3:0]};

  // Ready is withheld while reset is held so nothing is accepted during reset.
  assign read_addr_ready  = (state_q == IDLE) && !RESET;
  assign write_addr_ready = (state_q == IDLE) && !RESET;

  // Commit happens on the W_WAIT -> W_RESP edge; a reset on that edge drops it.
  assign arr_we = (state_q == W_WAIT) && (cnt_q == '0) && !RESET;

  line_mem_array #(
    .LINE_IDX_BITS(LINE_IDX_BITS)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(idx_q),
    .wdata(wdata_q),
    .raddr(idx_q),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      read_data        <= '0;
      read_data_valid  <= 1'b0;
      write_resp_valid <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Write wins so a writeback lands before a refill of the same line.
          if (write_addr_valid) begin
            state_q <= W_WAIT;
            idx_q   <= write_addr[LINE_IDX_BITS+3:4];
            wdata_q <= write_data;
            cnt_q   <= WrCntInit;
          end else if (read_addr_valid) begin
            state_q <= R_WAIT;
            idx_q   <= read_addr[LINE_IDX_BITS+3:4];
            cnt_q   <= RdCntInit;
          end
        end
        R_WAIT: begin
          if (cnt_q == '0) begin
            state_q         <= R_RESP;
            read_data       <= arr_rdata;
            read_data_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        R_RESP: begin
          if (read_data_ready) begin
            state_q         <= IDLE;
            read_data_valid <= 1'b0;
          end
        end
        W_WAIT: begin
          if (cnt_q == '0) begin
            state_q          <= W_RESP;
            write_resp_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        W_RESP: begin
          if (write_resp_ready) begin
            state_q          <= IDLE;
            write_resp_valid <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem.sv
module tb_line_mem;

  localparam int unsigned IdxBits = 12;
  localparam int RdLat = 4;
  localparam int WrLat = 4;
  localparam int Bound = 300;

  logic         clk = 1'b0;
  logic         RESET;
  logic [31:0]  read_addr;
  logic         read_addr_valid;
  logic         read_addr_ready;
  logic [127:0] read_data;
  logic         read_data_valid;
  logic         read_data_ready;
  logic [31:0]  write_addr;
  logic         write_addr_valid;
  logic         write_addr_ready;
  logic [127:0] write_data;
  logic         write_resp_valid;
  logic         write_resp_ready;

  int total = 0;
  int bad   = 0;

  // Reference memory: line index -> contents; absent entries read as zero.
  logic [127:0] model [int];

  always #5 clk = ~clk;

  line_mem #(
    .LINE_IDX_BITS(IdxBits),
    .READ_LATENCY (RdLat),
    .WRITE_LATENCY(WrLat)
  ) dut (
    .clk             (clk),
    .RESET           (RESET),
    .read_addr       (read_addr),
    .read_addr_valid (read_addr_valid),
    .read_addr_ready (read_addr_ready),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .read_data_ready (read_data_ready),
    .write_addr      (write_addr),
    .write_addr_valid(write_addr_valid),
    .write_addr_ready(write_addr_ready),
    .write_data      (write_data),
    .write_resp_valid(write_resp_valid),
    .write_resp_ready(write_resp_ready)
  );

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 4) % (32'd1 << IdxBits));
  endfunction

  function automatic logic [127:0] model_read(input logic [31:0] a);
    if (model.exists(line_of(a))) return model[line_of(a)];
    return '0;
  endfunction

  task automatic wait_idle(output bit to);
    int n = 0;
    to = 0;
    while (!write_addr_ready && n < Bound) begin
      @(negedge clk);
      n++;
    end
    if (!write_addr_ready) to = 1;
  endtask

  // Issues one write; lat counts edges from acceptance to first visible response.
  task automatic do_write(input logic [31:0] a, input logic [127:0] d, input int hold,
                          output int lat, output bit busy_rdy, output bit to);
    lat = 0;
    busy_rdy = 0;
    @(negedge clk);
    wait_idle(to);
    if (to) return;
    write_addr = a;
    write_data = d;
    write_addr_valid = 1'b1;
    @(negedge clk);
    write_addr_valid = 1'b0;
    write_data = ~d;
    while (!write_resp_valid && lat < Bound) begin
      if (read_addr_ready || write_addr_ready) busy_rdy = 1;
      @(negedge clk);
      lat++;
    end
    if (!write_resp_valid) begin
      to = 1;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      if (!write_resp_valid || read_addr_ready || write_addr_ready) busy_rdy = 1;
      @(negedge clk);
    end
    write_resp_ready = 1'b1;
    @(negedge clk);
    write_resp_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int hold, output logic [127:0] d,
                         output int lat, output bit busy_rdy, output bit to);
    lat = 0;
    busy_rdy = 0;
    d = 'x;
    @(negedge clk);
    wait_idle(to);
    if (to) return;
    read_addr = a;
    read_addr_valid = 1'b1;
    @(negedge clk);
    read_addr_valid = 1'b0;
    while (!read_data_valid && lat < Bound) begin
      if (read_addr_ready || write_addr_ready) busy_rdy = 1;
      @(negedge clk);
      lat++;
    end
    if (!read_data_valid) begin
      to = 1;
      return;
    end
    d = read_data;
    for (int i = 0; i < hold; i++) begin
      if (!read_data_valid || read_data !== d || read_addr_ready || write_addr_ready)
        busy_rdy = 1;
      @(negedge clk);
    end
    read_data_ready = 1'b1;
    @(negedge clk);
    read_data_ready = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (read_addr_ready !== 1'b0 || write_addr_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got r=%b w=%b want 0 0", read_addr_ready, write_addr_ready);
    end
    total++;
    if (read_data_valid !== 1'b0 || write_resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got rdv=%b wrv=%b want 0 0", read_data_valid,
               write_resp_valid);
    end
    total++;
    if (read_data !== 128'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", read_data);
    end
    RESET = 1'b0;
    @(negedge clk);
    total++;
    if (read_addr_ready !== 1'b1 || write_addr_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready: got r=%b w=%b want 1 1", read_addr_ready, write_addr_ready);
    end
  endtask

  task automatic test_basic_read;
    logic [127:0] d;
    int lat;
    bit busy, to;
    do_read(32'h0000_0040, 0, d, lat, busy, to);
    total++;
    if (to || lat !== RdLat) begin
      bad++;
      $display("FAIL read_latency: got %0d (timeout=%0b) want %0d", lat, to, RdLat);
    end
    total++;
    if (d !== 128'h0) begin
      bad++;
      $display("FAIL read_zero: got %h want 0", d);
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL read_busy_ready: ready seen high while busy, want low");
    end
  endtask

  task automatic test_write_read;
    logic [127:0] d;
    logic [127:0] wd = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    int lat;
    bit busy, to;
    do_write(32'h0000_1230, wd, 0, lat, busy, to);
    model[line_of(32'h0000_1230)] = wd;
    total++;
    if (to || lat !== WrLat) begin
      bad++;
      $display("FAIL write_latency: got %0d (timeout=%0b) want %0d", lat, to, WrLat);
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL write_busy_ready: ready seen high while busy, want low");
    end
    do_read(32'h0000_123C, 0, d, lat, busy, to);
    total++;
    if (to || d !== wd) begin
      bad++;
      $display("FAIL write_then_read: got %h want %h", d, wd);
    end
  endtask

  task automatic test_simultaneous;
    int lat = 0;
    bit to, rd_early = 0;
    logic [127:0] d;
    @(negedge clk);
    wait_idle(to);
    read_addr = 32'h0000_0100;
    read_addr_valid = 1'b1;
    write_addr = 32'h0000_0100;
    write_data = 128'h1;
    write_addr_valid = 1'b1;
    @(negedge clk);
    write_addr_valid = 1'b0;
    model[line_of(32'h0000_0100)] = 128'h1;
    while (!write_resp_valid && lat < Bound) begin
      if (read_data_valid) rd_early = 1;
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== WrLat || rd_early || read_data_valid !== 1'b0) begin
      bad++;
      $display("FAIL simul_write_first: wr lat %0d want %0d, read resp early=%0b", lat, WrLat,
               rd_early | read_data_valid);
    end
    write_resp_ready = 1'b1;
    @(negedge clk);
    write_resp_ready = 1'b0;
    // Read is still pending; wait for it to be taken.
    wait_idle(to);
    @(negedge clk);
    read_addr_valid = 1'b0;
    lat = 0;
    while (!read_data_valid && lat < Bound) begin
      @(negedge clk);
      lat++;
    end
    d = read_data;
    total++;
    if (!read_data_valid || d !== 128'h1) begin
      bad++;
      $display("FAIL simul_read_after: got %h valid=%b want 1 valid=1", d, read_data_valid);
    end
    read_data_ready = 1'b1;
    @(negedge clk);
    read_data_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [127:0] d0;
    int lat = 0, unstable = 0;
    bit to;
    @(negedge clk);
    wait_idle(to);
    read_addr = 32'h0000_1230;
    read_addr_valid = 1'b1;
    @(negedge clk);
    read_addr_valid = 1'b0;
    while (!read_data_valid && lat < Bound) begin
      @(negedge clk);
      lat++;
    end
    d0 = read_data;
    // Competing requests must not be accepted while the response is held.
    write_addr = 32'h0000_0500;
    write_data = 128'h77;
    write_addr_valid = 1'b1;
    read_addr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!read_data_valid || read_data !== d0 || read_addr_ready || write_addr_ready)
        unstable++;
      @(negedge clk);
    end
    total++;
    if (unstable != 0 || d0 !== model_read(32'h0000_1230)) begin
      bad++;
      $display("FAIL backpressure: %0d unstable cycles, data %h want %h", unstable, d0,
               model_read(32'h0000_1230));
    end
    write_addr_valid = 1'b0;
    read_addr_valid = 1'b0;
    read_data_ready = 1'b1;
    @(negedge clk);
    read_data_ready = 1'b0;
  endtask

  task automatic test_alias;
    logic [127:0] d;
    int lat;
    bit busy, to;
    do_write(32'h0001_0020, 128'hA5, 0, lat, busy, to);
    model[line_of(32'h0001_0020)] = 128'hA5;
    do_read(32'h0000_0020, 0, d, lat, busy, to);
    total++;
    if (to || d !== 128'hA5) begin
      bad++;
      $display("FAIL alias: got %h want a5", d);
    end
  endtask

  task automatic test_reset_in_wait;
    logic [127:0] d;
    int lat, resp_seen = 0;
    bit busy, to;
    @(negedge clk);
    wait_idle(to);
    write_addr = 32'h0000_0080;
    write_data = 128'hFF;
    write_addr_valid = 1'b1;
    @(negedge clk);
    write_addr_valid = 1'b0;
    @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (write_resp_valid) resp_seen++;
      @(negedge clk);
    end
    total++;
    if (resp_seen != 0) begin
      bad++;
      $display("FAIL reset_abandon: write_resp_valid seen %0d cycles want 0", resp_seen);
    end
    do_read(32'h0000_0080, 0, d, lat, busy, to);
    total++;
    if (to || d !== model_read(32'h0000_0080)) begin
      bad++;
      $display("FAIL reset_drop_write: got %h want %h", d, model_read(32'h0000_0080));
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [127:0] d, wd;
    int lat, hold;
    bit busy, to;
    for (int n = 0; n < 40; n++) begin
      a = ($urandom & 32'hFFFF_0000) | ($urandom_range(0, 7) << 8) | 32'($urandom_range(0, 15));
      hold = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        wd = {$urandom, $urandom, $urandom, $urandom};
        do_write(a, wd, hold, lat, busy, to);
        model[line_of(a)] = wd;
        total++;
        if (to || lat !== WrLat || busy) begin
          bad++;
          $display("FAIL rand_write[%0d]: lat %0d want %0d busy=%0b to=%0b", n, lat, WrLat,
                   busy, to);
        end
      end else begin
        do_read(a, hold, d, lat, busy, to);
        total++;
        if (to || lat !== RdLat || busy || d !== model_read(a)) begin
          bad++;
          $display("FAIL rand_read[%0d] a=%h: got %h lat %0d want %h lat %0d busy=%0b", n, a,
                   d, lat, model_read(a), RdLat, busy);
        end
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    read_addr = '0;
    read_addr_valid = 1'b0;
    read_data_ready = 1'b0;
    write_addr = '0;
    write_addr_valid = 1'b0;
    write_data = '0;
    write_resp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_read();
    test_write_read();
    test_simultaneous();
    test_backpressure();
    test_alias();
    test_reset_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
